// File: rtl/uart_msg_checker_pkg.sv
// Shared definitions for the UART "HELLO\r\n" message checker:
// default message length, the expected byte pattern, the FSM state type
// and the width of the byte index.
package uart_msg_pkg;

  localparam int DEFAULT_MSG_LEN = 7;
  localparam int IDX_W           = 4;

  localparam logic [7:0] PATTERN [0:DEFAULT_MSG_LEN-1] =
    '{8'd72, 8'd69, 8'd76, 8'd76, 8'd79, 8'd13, 8'd10};

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    MATCH = 1'b1
  } state_t;

  // Looks up the expected byte for a message position; positions beyond
  // the stored pattern read as zero so a wide index never leaves the array.
  function automatic logic [7:0] pattern_at(input logic [IDX_W-1:0] pos);
    logic [7:0] value;
    value = 8'h00;
    for (int k = 0; k < DEFAULT_MSG_LEN; k++) begin
      if (pos == IDX_W'(k)) value = PATTERN[k];
    end
    return value;
  endfunction

endpackage

// File: rtl/uart_msg_checker_sat_counter.sv
// Saturating up-counter used for the good and bad message tallies.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one step per inc pulse, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_msg_checker.sv
// Receive-side checker for the periodic "HELLO\r\n" UART message.
// Frames the incoming byte stream, pulses msg_ok / msg_bad per message,
// keeps saturating good/bad counts and mirrors the last byte onto LEDs.
// Optional inter-byte timeout: define UART_MSG_CHECK_TIMEOUT_EN.
module uart_msg_checker
  import uart_msg_pkg::*;
#(
  parameter int MSG_LEN = DEFAULT_MSG_LEN,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             received,
  input  logic [7:0]       rx_byte,
  input  logic             recv_error,
  output logic             msg_ok,
  output logic             msg_bad,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count,
  output logic             hunting,
  output logic [7:0]       led
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_n;
  logic             ok_evt;
  logic             bad_evt;
  logic             byte_valid;

  // A framing error in the same cycle voids the byte entirely.
  assign byte_valid = received & ~recv_error;

`ifdef UART_MSG_CHECK_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TIMER_W-1:0] timer;
  logic               timer_hit;

  assign timer_hit = (timer == TIMER_W'(TIMEOUT - 1));

  // Inter-byte timer: runs only while waiting inside a message, restarts on every byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if ((state == MATCH) && (state_n == MATCH) && !received) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end
`else
  // No timer in this build; the parameter stays so both builds share one interface.
  localparam int timeout_unused = TIMEOUT;
`endif

  // Decide the next state, index and per-message event for this cycle's inputs.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    ok_evt  = 1'b0;
    bad_evt = 1'b0;
    case (state)
      HUNT: begin
        if (byte_valid && (rx_byte == PATTERN[0])) begin
          idx_n   = IDX_W'(1);
          state_n = MATCH;
        end
      end
      MATCH: begin
        if (recv_error) begin
          bad_evt = 1'b1;
          state_n = HUNT;
          idx_n   = '0;
        end else if (received) begin
          if (rx_byte == pattern_at(idx)) begin
            if (idx == LAST_IDX) begin
              ok_evt  = 1'b1;
              state_n = HUNT;
              idx_n   = '0;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            bad_evt = 1'b1;
            if (rx_byte == PATTERN[0]) begin
              idx_n = IDX_W'(1);
            end else begin
              state_n = HUNT;
              idx_n   = '0;
            end
          end
        end
`ifdef UART_MSG_CHECK_TIMEOUT_EN
        else if (timer_hit) begin
          bad_evt = 1'b1;
          state_n = HUNT;
          idx_n   = '0;
        end
`endif
      end
      default: begin
        state_n = HUNT;
        idx_n   = '0;
      end
    endcase
  end

  // Register the FSM and every status output so responses land one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HUNT;
      idx     <= '0;
      msg_ok  <= 1'b0;
      msg_bad <= 1'b0;
      hunting <= 1'b1;
      led     <= 8'h00;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      msg_ok  <= ok_evt;
      msg_bad <= bad_evt;
      hunting <= (state_n == HUNT);
      if (byte_valid) led <= rx_byte;
    end
  end

  sat_counter #(.W(CNT_W)) u_good_count (
    .clk   (clk),
    .reset (reset),
    .inc   (ok_evt),
    .count (good_count)
  );

  sat_counter #(.W(CNT_W)) u_bad_count (
    .clk   (clk),
    .reset (reset),
    .inc   (bad_evt),
    .count (bad_count)
  );

endmodule

// File: tb/tb_uart_msg_checker.sv
// Directed testbench for uart_msg_checker. A 16-bit-counter instance and a
// 2-bit-counter instance share the same stimulus; expected per-cycle
// results are queued as each stimulus step is driven and popped when the
// response cycle arrives.
module tb_uart_msg_checker;

  logic        clk;
  logic        reset;
  logic        received;
  logic [7:0]  rx_byte;
  logic        recv_error;

  logic        msg_ok;
  logic        msg_bad;
  logic [15:0] good_count;
  logic [15:0] bad_count;
  logic        hunting;
  logic [7:0]  led;

  logic        msg_ok_s;
  logic        msg_bad_s;
  logic [1:0]  good_count_s;
  logic [1:0]  bad_count_s;
  logic        hunting_s;
  logic [7:0]  led_s;

  uart_msg_checker #(.CNT_W(16), .TIMEOUT(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .received   (received),
    .rx_byte    (rx_byte),
    .recv_error (recv_error),
    .msg_ok     (msg_ok),
    .msg_bad    (msg_bad),
    .good_count (good_count),
    .bad_count  (bad_count),
    .hunting    (hunting),
    .led        (led)
  );

  uart_msg_checker #(.CNT_W(2), .TIMEOUT(100)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .received   (received),
    .rx_byte    (rx_byte),
    .recv_error (recv_error),
    .msg_ok     (msg_ok_s),
    .msg_bad    (msg_bad_s),
    .good_count (good_count_s),
    .bad_count  (bad_count_s),
    .hunting    (hunting_s),
    .led        (led_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ok;
    logic        bad;
    logic        hunt;
    logic [7:0]  led;
    logic [15:0] good;
    logic [15:0] bad_cnt;
    logic [1:0]  good_sat;
    logic [1:0]  bad_sat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic [7:0]  msg_bytes [0:6] = '{8'd72, 8'd69, 8'd76, 8'd76, 8'd79, 8'd13, 8'd10};
  logic [15:0] exp_good;
  logic [15:0] exp_bad;
  logic [1:0]  exp_good_sat;
  logic [1:0]  exp_bad_sat;
  logic [7:0]  exp_led;
  logic        exp_hunt;

  // Single comparison point: counts the check and reports any difference.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Pop the oldest expectation and compare it with both instances.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".msg_ok"},       msg_ok,       e.ok);
    chk({e.tag, ".msg_bad"},      msg_bad,      e.bad);
    chk({e.tag, ".hunting"},      hunting,      e.hunt);
    chk({e.tag, ".led"},          led,          e.led);
    chk({e.tag, ".good_count"},   good_count,   e.good);
    chk({e.tag, ".bad_count"},    bad_count,    e.bad_cnt);
    chk({e.tag, ".sat.msg_ok"},   msg_ok_s,     e.ok);
    chk({e.tag, ".sat.msg_bad"},  msg_bad_s,    e.bad);
    chk({e.tag, ".sat.good"},     good_count_s, e.good_sat);
    chk({e.tag, ".sat.bad"},      bad_count_s,  e.bad_sat);
  endtask

  // Drive one cycle of inputs, queue what must appear next cycle, then check it.
  task automatic applyStimulus(input logic [7:0] b, input logic rcv, input logic err,
                               input logic want_ok, input logic want_bad,
                               input logic hunt_after, input string tag);
    exp_t e;
    rx_byte    = b;
    received   = rcv;
    recv_error = err;
    if (want_ok) begin
      if (exp_good != 16'hFFFF) exp_good++;
      if (exp_good_sat != 2'b11) exp_good_sat++;
    end
    if (want_bad) begin
      if (exp_bad != 16'hFFFF) exp_bad++;
      if (exp_bad_sat != 2'b11) exp_bad_sat++;
    end
    if (rcv && !err) exp_led = b;
    exp_hunt   = hunt_after;
    e.ok       = want_ok;
    e.bad      = want_bad;
    e.hunt     = hunt_after;
    e.led      = exp_led;
    e.good     = exp_good;
    e.bad_cnt  = exp_bad;
    e.good_sat = exp_good_sat;
    e.bad_sat  = exp_bad_sat;
    e.tag      = tag;
    sb.push_back(e);
    @(negedge clk);
    received   = 1'b0;
    recv_error = 1'b0;
    rx_byte    = 8'h00;
    checkOutput();
  endtask

  // Quiet cycles: no pulses, hunting and counts hold.
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, ".idle.msg_ok"},  msg_ok,    1'b0);
      chk({tag, ".idle.msg_bad"}, msg_bad,   1'b0);
      chk({tag, ".idle.hunting"}, hunting,   exp_hunt);
      chk({tag, ".idle.bad_cnt"}, bad_count, exp_bad);
    end
  endtask

  // One-cycle synchronous reset followed by a check of every reset value.
  task automatic doReset(input string tag);
    received   = 1'b0;
    recv_error = 1'b0;
    rx_byte    = 8'h00;
    reset      = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    exp_good     = '0;
    exp_bad      = '0;
    exp_good_sat = '0;
    exp_bad_sat  = '0;
    exp_led      = 8'h00;
    exp_hunt     = 1'b1;
    chk({tag, ".reset.msg_ok"},  msg_ok,       1'b0);
    chk({tag, ".reset.msg_bad"}, msg_bad,      1'b0);
    chk({tag, ".reset.good"},    good_count,   16'd0);
    chk({tag, ".reset.bad"},     bad_count,    16'd0);
    chk({tag, ".reset.hunting"}, hunting,      1'b1);
    chk({tag, ".reset.led"},     led,          8'd0);
    chk({tag, ".reset.sat"},     good_count_s, 2'd0);
  endtask

  // Full "HELLO\r\n" with the given number of quiet cycles between bytes.
  task automatic sendMsg(input int gap, input string tag);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(msg_bytes[i], 1'b1, 1'b0, (i == 6), 1'b0, (i == 6),
                    $sformatf("%s.b%0d", tag, i));
      idle(gap, tag);
    end
  endtask

  initial begin
    reset      = 1'b1;
    received   = 1'b0;
    recv_error = 1'b0;
    rx_byte    = 8'h00;
    repeat (3) @(negedge clk);

    // Clean message, strobes 20 cycles apart.
    doReset("clean");
    sendMsg(19, "clean");

    // Noise bytes in HUNT are ignored and not counted.
    doReset("noise");
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "noise.00");
    applyStimulus(8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "noise.41");
    sendMsg(2, "noise");

    // Mismatch on a start byte resyncs straight into the next message.
    doReset("resync");
    applyStimulus(8'd72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "resync.H");
    applyStimulus(8'd69, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "resync.E");
    applyStimulus(8'd72, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "resync.H2");
    applyStimulus(8'd69, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "resync.E2");
    applyStimulus(8'd76, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "resync.L1");
    applyStimulus(8'd76, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "resync.L2");
    applyStimulus(8'd79, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "resync.O");
    applyStimulus(8'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "resync.CR");
    applyStimulus(8'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "resync.LF");
    idle(3, "resync");

    // Framing errors: abort in MATCH, ignored in HUNT, and always beat a byte.
    doReset("err");
    applyStimulus(8'd72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "err.H");
    applyStimulus(8'd69, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "err.E");
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "err.abort");
    applyStimulus(8'd72, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "err.hunt_both");
    applyStimulus(8'd72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "err.H3");
    applyStimulus(8'd69, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "err.match_both");
    idle(2, "err");

    // Saturation of the 2-bit instance on both counters; pulses keep firing.
    doReset("sat");
    for (int m = 0; m < 5; m++) sendMsg(1, $sformatf("sat.good%0d", m));
    for (int m = 0; m < 4; m++) begin
      applyStimulus(8'd72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("sat.badH%0d", m));
      applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, $sformatf("sat.badX%0d", m));
    end
    idle(2, "sat");

    // Reset in the middle of a message discards it silently.
    doReset("midrst");
    applyStimulus(8'd72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "midrst.H");
    applyStimulus(8'd69, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "midrst.E");
    applyStimulus(8'd76, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "midrst.L");
    doReset("midrst2");
    sendMsg(2, "midrst");

    // Long idle after a start byte: expires only when the timer is built in.
    doReset("tmo");
    applyStimulus(8'd72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "tmo.H");
    idle(99, "tmo");
`ifdef UART_MSG_CHECK_TIMEOUT_EN
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "tmo.expire");
`else
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "tmo.wait");
`endif

    // A byte landing on the expiry cycle wins; the timer then restarts.
    doReset("tmob");
    applyStimulus(8'd72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "tmob.H");
    idle(99, "tmob");
    applyStimulus(8'd69, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "tmob.E_on_expiry");
    idle(99, "tmob2");
`ifdef UART_MSG_CHECK_TIMEOUT_EN
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "tmob.expire");
`else
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "tmob.wait");
`endif
    idle(2, "end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_msg_checker.md
Name: uart_msg_checker

Overview:
- Receive-side companion to the periodic UART message generator.
- Consumes the byte stream from the `uart` receiver (`received` strobe plus `rx_byte`).
- Frames and checks the fixed 7-byte message "HELLO\r\n" (72, 69, 76, 76, 79, 13, 10).
- Counts good and bad messages, pulses per-message status, and mirrors the last received byte onto LEDs for board bring-up.

Parameters:
- MSG_LEN, 7: number of bytes in the expected message; must be ≥ 2 and ≤ 16.
- CNT_W, 16: width of the good/bad message counters.
- TIMEOUT, 2000000: max clk cycles allowed between consecutive bytes inside a message (used only with the optional feature).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- received, in, 1: one-cycle strobe from the UART receiver; `rx_byte` is valid in that cycle.
- rx_byte, in, 8: received byte.
- recv_error, in, 1: one-cycle strobe; UART framing error.
- msg_ok, out, 1: one-cycle pulse when a complete correct message has been received.
- msg_bad, out, 1: one-cycle pulse when a started message is aborted.
- good_count, out, CNT_W: saturating count of good messages.
- bad_count, out, CNT_W: saturating count of bad messages.
- hunting, out, 1: high while in HUNT state.
- led, out, 8: last byte accepted via `received`.

Behaviour:
- Reset: already decided — `reset` is synchronous and active-high; clock is `clk`. All outputs are registered. Reset values:
  - state = HUNT, idx = 0
  - msg_ok = 0, msg_bad = 0
  - good_count = 0, bad_count = 0
  - hunting = 1, led = 0
  - inter-byte timer = 0
- Reset mid-message: the partial message is discarded; no `msg_bad` and no count change.
- Latency: every response (`msg_ok`, `msg_bad`, count change, `led`, `hunting`) appears exactly 1 cycle after the input strobe that causes it.
- `led`: loads `rx_byte` on every `received` that has no simultaneous `recv_error`, in any state.
- State HUNT:
  - `received` with `rx_byte` == PATTERN[0]: idx ← 1, go to MATCH.
  - Any other byte: ignored, stay in HUNT; not counted as bad.
  - `recv_error`: ignored.
- State MATCH, on `received`:
  - `rx_byte` == PATTERN[idx] and idx == MSG_LEN-1: pulse `msg_ok`, good_count++, go to HUNT.
  - `rx_byte` == PATTERN[idx] and idx < MSG_LEN-1: idx++.
  - Mismatch: pulse `msg_bad`, bad_count++. Then resync:
    - byte == PATTERN[0]: stay in MATCH, idx ← 1.
    - otherwise: go to HUNT, idx ← 0.
- State MATCH, on `recv_error`: pulse `msg_bad`, bad_count++, go to HUNT.
- `received` and `recv_error` in the same cycle: the error wins; the byte is not compared and `led` is not updated.
- Counters: saturate at 2^CNT_W-1 and do not wrap. The `msg_ok`/`msg_bad` pulses still fire when a counter is saturated.
- No cycle can assert both `msg_ok` and `msg_bad`.
- PATTERN is a constant. No runtime reprogramming.

Optional Feature:
- Macro: UART_MSG_CHECK_TIMEOUT_EN.
- Defined:
  - The timer clears on entry to MATCH and on each `received` while in MATCH.
  - Otherwise it increments each cycle in MATCH.
  - When the timer reaches TIMEOUT-1 with no `received` or `recv_error` that cycle: pulse `msg_bad`, bad_count++, go to HUNT.
  - A byte arriving in the same cycle as expiry is processed normally; the byte wins.
  - Timer is held at 0 in HUNT.
- Undefined: no timer logic is present; MATCH waits indefinitely for the next byte.

Decomposition:
- Package `uart_msg_pkg` holds:
  - MSG_LEN default
  - PATTERN constant array `[0:MSG_LEN-1]` of 8-bit
  - state typedef (HUNT, MATCH)
  - idx width constant (4 bits)
- One sub-module: `sat_counter` (parameter W; ports clk, reset, inc, count), instantiated twice for good_count and bad_count.
- The FSM, compare logic, and timer stay in the top module.

Test Plan:
- Clean message: drive 72,69,76,76,79,13,10 with strobes 20 cycles apart → one `msg_ok` pulse 1 cycle after byte 10; good_count=1, bad_count=0, led=10, hunting=1.
- Noise then message: drive 0x00, 0x41, then "HELLO\r\n" → bad_count stays 0, good_count=1.
- Mismatch with resync: drive 72,69,72,69,76,76,79,13,10 → `msg_bad` 1 cycle after the third byte; bad_count=1, good_count=1.
- Errors:
  - Drive 72,69, then `recv_error` → bad_count=1, hunting=1.
  - Then drive `received`=1 and `recv_error`=1 together with byte 72 → led unchanged, hunting stays 1.
- Saturation: with CNT_W=2, send 5 good messages → good_count=3; the 5th `msg_ok` still pulses.
- Reset mid-message: drive 72,69,76, assert reset → all outputs return to reset values, bad_count=0; then a clean message gives good_count=1.
- Timeout (macro defined, TIMEOUT=100): drive 72, then idle for 100 cycles → `msg_bad` on the expiry cycle +1, bad_count=1, hunting=1. Without the macro, the same stimulus leaves hunting=0 and bad_count=0.
